// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude capture, radix-2 shift-add multiply / restoring divide step, sign fix and result register.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             special,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b_q;
  logic               neg_res;
  logic               neg_rem;
  logic [CNT_W-1:0]   cnt;

  logic               sign_a, sign_b, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_val;

  always_comb begin
    sign_a   = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    sign_b   = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    neg_a    = sign_a & operand_a[WIDTH-1];
    neg_b    = sign_b & operand_b[WIDTH-1];
    mag_a    = neg_a ? -operand_a : operand_a;
    mag_b    = neg_b ? -operand_b : operand_b;
    div_zero = (operand_b == '0);
    div_ovf  = sign_b && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
    special  = op[2] & (div_zero | div_ovf);
    // op[1] separates REM/REMU from DIV/DIVU within the divide group
    if (div_zero)
      special_val = op[1] ? operand_a : '1;
    else
      special_val = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, rem_sh} - {2'b00, mag_b_q};
    if (diff[WIDTH+1])
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem_v, fix_val;

  always_comb begin
    prod  = neg_res ? -acc : acc;
    quot  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_v = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_q)
      MD_MUL:                       fix_val = prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              fix_val = quot;
      default:                      fix_val = rem_v;
    endcase
  end

  assign last = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      acc     <= '0;
      mag_b_q <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else if (load) begin
      op_q    <= op;
      acc     <= {{WIDTH{1'b0}}, mag_a};
      mag_b_q <= mag_b;
      neg_res <= neg_a ^ neg_b;
      neg_rem <= neg_a;
      cnt     <= '0;
      if (special)
        result <= special_val;
    end else if (step) begin
      acc <= op_q[2] ? div_next : mul_next;
      cnt <= cnt + 1'b1;
    end else if (fix) begin
      result <= fix_val;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide: FSM and start/busy/done handshake around muldiv_datapath.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  md_state_t state_q, state_d;
  logic      load, step, fix, special, last;

  muldiv_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .special   (special),
    .last      (last),
    .result    (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          state_d = special ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        // a flush here must leave the previous result untouched
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          fix     = 1'b1;
          state_d = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q != MD_IDLE);
  assign done = (state_q == MD_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of muldiv_sequencer against a behavioural RV32M model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = int'(a);
    ib = int'(b);
    r  = '0;
    case (o)
      3'd0: begin up = ua * ub; r = up[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= 3'd4 && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // presents a request for one cycle; cyc is 1 in the cycle after the accept edge
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input int el);
    exp_q.push_back(er);
    lat_q.push_back(el);
    drive(o, a, b);
  endtask

  task automatic finish_op(input string tag);
    logic [31:0] er;
    int el;
    while (!done && cyc < 200) tick();
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, " latency"}, 32'(cyc), 32'(el));
    check({tag, " result"}, result, er);
    check({tag, " busy at done"}, 32'(busy), 32'd1);
    tick();
    check({tag, " done clears"}, 32'(done), 32'd0);
    check({tag, " busy clears"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input int el);
    issue(o, a, b, er, el);
    finish_op(tag);
  endtask

  initial begin
    int dn;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);

    run("MUL 7*6",       3'd0, 32'd7,          32'd6,          32'd42,         34);
    run("MULHU max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34);
    run("MULH -1*2",     3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34);
    run("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34);
    run("DIV -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    run("REM -7%2",      3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    run("DIVU 100/7",    3'd5, 32'd100,        32'd7,          32'd14,         34);
    run("REMU 100%7",    3'd7, 32'd100,        32'd7,          32'd2,          34);
    run("DIVU 5/0",      3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    run("REM 5%0",       3'd6, 32'd5,          32'd0,          32'd5,          1);
    run("DIV ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    run("REM ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

    // start pulsed mid-operation must be ignored
    issue(3'd0, 32'd7, 32'd6, 32'd42, 34);
    while (cyc < 10) tick();
    op = 3'd3; operand_a = 32'd100; operand_b = 32'd200; start = 1'b1;
    tick();
    start = 1'b0;
    finish_op("MUL ignore start");

    // flush mid-CALC: back to IDLE, no done, result held
    drive(3'd0, 32'd3, 32'd3);
    while (cyc < 12) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    dn = 0;
    repeat (40) begin tick(); if (done) dn++; end
    check("flush no done pulse", 32'(dn), 32'd0);
    check("flush result held", result, 32'd42);

    // flush wins over start in IDLE
    @(negedge clk);
    op = 3'd0; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush beats start", 32'(busy), 32'd0);

    // asynchronous reset mid-CALC
    drive(3'd5, 32'd100, 32'd7);
    while (cyc < 5) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("DIVU 9/3 after rst", 3'd5, 32'd9, 32'd3, 32'd3, 34);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
